// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in/parallel-out capture stage. Collects bit_in on each
//               bit_en strobe into WIDTH-bit words and presents each completed
//               word on a one-entry output slot with a valid/ready handshake.
//               A sticky overrun flag records words dropped because the slot
//               was still occupied.
// Ports       : clk, rst_n (async, active-low)
//               bit_in, bit_en   - serial data and its sample strobe
//               clear            - synchronous abort of the partial word,
//                                  also clears overrun
//               word_out, word_valid, word_ready - output slot handshake
//               bit_cnt          - bits collected in the current frame
//               overrun          - sticky dropped-word flag
//               parity_err       - even-parity error of the held word
// Options     : define SIPO_PARITY_EN to append one even-parity bit to every
//               frame and report parity_err; otherwise parity_err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     bit_in,
    input  logic                     bit_en,
    input  logic                     clear,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(WIDTH):0]   bit_cnt,
    output logic                     overrun,
    output logic                     parity_err
);

    localparam int c_CNT_W = $clog2(WIDTH) + 1;
`ifdef SIPO_PARITY_EN
    localparam int c_FRAME_BITS = WIDTH + 1;
`else
    localparam int c_FRAME_BITS = WIDTH;
`endif
    localparam logic [c_CNT_W-1:0] c_LAST_BIT  = c_CNT_W'(c_FRAME_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_BITS = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_word_done;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_word;
    logic               r_overrun;
    logic               w_accept;
    logic               w_shift_en;
    logic               w_complete;
    logic               w_load;
    logic               w_drop;

    // clear has priority over a coincident strobe
    assign w_accept   = bit_en & ~clear;
    // only data bits enter the shift register; a trailing parity bit does not
    assign w_shift_en = w_accept & (r_cnt < c_DATA_BITS);
    assign w_complete = w_accept & (r_cnt == c_LAST_BIT);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], bit_in};
        end else begin : g_lsb_first
            assign w_shift_next = {bit_in, r_shift[WIDTH-1:1]};
        end
    endgenerate

`ifdef SIPO_PARITY_EN
    // completion happens on the parity bit, so all data is already held
    assign w_word_done = r_shift;
`else
    // completion happens on the last data bit, which is not yet registered
    assign w_word_done = w_shift_next;
`endif

    // ------------------------------------------------------------------
    // Collect path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (bit_en) begin
            if (w_shift_en) begin
                r_shift <= w_shift_next;
            end
            r_cnt <= w_complete ? '0 : (r_cnt + c_CNT_ONE);
        end
    end

    // ------------------------------------------------------------------
    // Output slot FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_complete) begin
                    w_load       = 1'b1;
                    w_state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_complete) begin
                    // a word draining this cycle makes room for the new one
                    if (word_ready) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else if (word_ready) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
        end else if (w_load) begin
            r_word <= w_word_done;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

`ifdef SIPO_PARITY_EN
    logic r_par;
    logic r_perr;

    // running XOR of the data bits of the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (clear || w_complete) begin
            r_par <= 1'b0;
        end else if (w_shift_en) begin
            r_par <= r_par ^ bit_in;
        end
    end

    // the parity flag travels with the word it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr <= 1'b0;
        end else if (w_load) begin
            r_perr <= r_par ^ bit_in;
        end
    end

    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

    assign word_out   = r_word;
    assign word_valid = (r_state == ST_FULL);
    assign bit_cnt    = r_cnt;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Self-checking bench for sipo_deserializer. Two instances
//               (MSB-first and LSB-first) share one stimulus stream and are
//               compared against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;
    localparam int CW    = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bit_in;
    logic          bit_en;
    logic          clear;
    logic          word_ready;
    logic [W-1:0]  word_out_m, word_out_l;
    logic          word_valid_m, word_valid_l;
    logic [CW-1:0] bit_cnt_m, bit_cnt_l;
    logic          overrun_m, overrun_l;
    logic          parity_err_m, parity_err_l;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .clear      (clear),
        .word_out   (word_out_m),
        .word_valid (word_valid_m),
        .word_ready (word_ready),
        .bit_cnt    (bit_cnt_m),
        .overrun    (overrun_m),
        .parity_err (parity_err_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_en     (bit_en),
        .clear      (clear),
        .word_out   (word_out_l),
        .word_valid (word_valid_l),
        .word_ready (word_ready),
        .bit_cnt    (bit_cnt_l),
        .overrun    (overrun_l),
        .parity_err (parity_err_l)
    );

    // ---------------- reference model ----------------
    bit           mq[$];        // bits of the frame in arrival order
    logic [W-1:0] m_word_m;
    logic [W-1:0] m_word_l;
    logic         m_valid;
    logic         m_ovr;
    logic         m_perr;

    task automatic model_reset();
        mq.delete();
        m_word_m = '0;
        m_word_l = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_perr   = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic en, input logic clr, input logic rdy);
        logic         done = 1'b0;
        logic [W-1:0] wm   = '0;
        logic [W-1:0] wl   = '0;
        logic         pe   = 1'b0;
        if (clr) begin
            mq.delete();
            m_ovr = 1'b0;
        end else if (en) begin
            mq.push_back(b);
            if (mq.size() == FRAME) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = mq[i];
                    wl[i]     = mq[i];
                end
                for (int i = 0; i < FRAME; i++) pe ^= mq[i];
                mq.delete();
            end
        end
        if (m_valid && rdy) m_valid = 1'b0;
        if (done) begin
            if (!m_valid) begin
                m_valid  = 1'b1;
                m_word_m = wm;
                m_word_l = wl;
                m_perr   = (PAR != 0) ? pe : 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " m.word_valid"}, 32'(word_valid_m), 32'(m_valid));
        chk({tag, " m.word_out"},   32'(word_out_m),   32'(m_word_m));
        chk({tag, " m.bit_cnt"},    32'(bit_cnt_m),    32'(mq.size()));
        chk({tag, " m.overrun"},    32'(overrun_m),    32'(m_ovr));
        chk({tag, " m.parity_err"}, 32'(parity_err_m), 32'(m_perr));
        chk({tag, " l.word_valid"}, 32'(word_valid_l), 32'(m_valid));
        chk({tag, " l.word_out"},   32'(word_out_l),   32'(m_word_l));
        chk({tag, " l.bit_cnt"},    32'(bit_cnt_l),    32'(mq.size()));
        chk({tag, " l.overrun"},    32'(overrun_l),    32'(m_ovr));
        chk({tag, " l.parity_err"}, 32'(parity_err_l), 32'(m_perr));
    endtask

    // drive one clock of inputs, advance the model, sample 1 time unit later
    task automatic step(input string tag, input logic b, input logic en,
                        input logic clr, input logic rdy);
        bit_in     = b;
        bit_en     = en;
        clear      = clr;
        word_ready = rdy;
        @(posedge clk);
        if (rst_n) model_edge(b, en, clr, rdy);
        #1;
        check_all(tag);
    endtask

    // send one frame MSB-of-d first; gap idle cycles precede each strobe after
    // the first; the final strobe of the frame uses rdy_last
    task automatic send(input string tag, input logic [W-1:0] d, input int gap,
                        input logic rdy, input logic rdy_last, input logic bad_par);
        logic [W-1:0] dv = d;
        for (int i = 0; i < FRAME; i++) begin
            logic bv = (i < W) ? dv[W-1-i] : (^dv ^ bad_par);
            if (i > 0) for (int g = 0; g < gap; g++) step(tag, 1'b0, 1'b0, 1'b0, rdy);
            step(tag, bv, 1'b1, 1'b0, (i == FRAME-1) ? rdy_last : rdy);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_en     = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // idle: nothing changes
        for (int i = 0; i < 20; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // basic capture: 1,0,1,1,0,0,1,0
        send("basic", 8'hB2, 0, 1'b1, 1'b1, 1'b0);
        chk("basic m.word_out", 32'(word_out_m), 32'h0000_00B2);
        chk("basic l.word_out", 32'(word_out_l), 32'h0000_004D);
        chk("basic valid", 32'(word_valid_m), 32'd1);
        step("basic drain", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic valid one cycle", 32'(word_valid_m), 32'd0);

        // sparse strobes every 3rd cycle
        send("sparse", 8'hB2, 2, 1'b1, 1'b1, 1'b0);
        chk("sparse l.word_out", 32'(word_out_l), 32'h0000_004D);
        chk("sparse bit_cnt wrap", 32'(bit_cnt_l), 32'd0);
        step("sparse drain", 1'b0, 1'b0, 1'b0, 1'b1);

        // back-pressure and overrun
        send("bp1", 8'hA5, 0, 1'b0, 1'b0, 1'b0);
        send("bp2", 8'h3C, 0, 1'b0, 1'b0, 1'b0);
        chk("bp m.word_out held", 32'(word_out_m), 32'h0000_00A5);
        chk("bp overrun", 32'(overrun_m), 32'd1);
        step("bp drain", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp drained valid", 32'(word_valid_m), 32'd0);
        chk("bp overrun sticky", 32'(overrun_m), 32'd1);
        step("bp clear", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp overrun cleared", 32'(overrun_l), 32'd0);

        // simultaneous drain and load
        send("sim1", 8'h11, 0, 1'b0, 1'b0, 1'b0);
        send("sim2", 8'h22, 0, 1'b0, 1'b1, 1'b0);
        chk("sim m.word_out", 32'(word_out_m), 32'h0000_0022);
        chk("sim valid", 32'(word_valid_m), 32'd1);
        chk("sim overrun", 32'(overrun_m), 32'd0);
        step("sim drain", 1'b0, 1'b0, 1'b0, 1'b1);

        // clear mid-word, then parity frames
        for (int i = 0; i < 4; i++) step("cmw bits", 1'b1, 1'b1, 1'b0, 1'b1);
        step("cmw clear", 1'b1, 1'b1, 1'b1, 1'b1);
        chk("cmw bit_cnt", 32'(bit_cnt_m), 32'd0);
        send("par0", 8'h0F, 0, 1'b1, 1'b1, 1'b0);
        chk("par0 m.word_out", 32'(word_out_m), 32'h0000_000F);
        chk("par0 parity_err", 32'(parity_err_m), 32'd0);
        step("par0 drain", 1'b0, 1'b0, 1'b0, 1'b1);
        send("par1", 8'h07, 0, 1'b1, 1'b1, 1'b1);
        chk("par1 m.word_out", 32'(word_out_m), 32'h0000_0007);
        chk("par1 parity_err", 32'(parity_err_m), 32'(PAR));
        step("par1 drain", 1'b0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-word and mid-cycle
        send("pre-rst", 8'hC3, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("pre-rst bits", 1'b1, 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async rst");
        step("rst hold", 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step("post-rst idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(1, 0)),
                 ($urandom_range(2, 0) != 0),
                 ($urandom_range(40, 0) == 0),
                 ($urandom_range(3, 0) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out capture stage directly downstream of the enable-gated d-flip-flop cell: it consumes the registered q bit stream, qualified by a bit strobe, and assembles WIDTH-bit words. Completed words are presented on a one-entry output register with a valid/ready handshake to the next lab stage. A sticky overrun flag records words lost because the output slot was still occupied.

Parameters:
WIDTH, 8, number of serial bits per assembled word (2..32)
MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first bit lands in word_out[0]

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
bit_in  input  1  serial data bit (driven from the upstream flip-flop q)
bit_en  input  1  strobe: bit_in is sampled on this clock edge when high
clear  input  1  synchronous abort: discards the partial word, clears overrun
word_out  output  WIDTH  assembled word, stable while word_valid=1
word_valid  output  1  output slot holds an unconsumed word
word_ready  input  1  downstream accepts word_out when word_valid=1
bit_cnt  output  $clog2(WIDTH)+1  bits collected in the current partial word
overrun  output  1  sticky: a completed word was dropped
parity_err  output  1  see Optional Feature

Behaviour:
- Reset (rst_n=0, asynchronous): shift register=0, bit_cnt=0, word_out=0, word_valid=0, overrun=0, parity_err=0. Reset mid-word discards all partial data.
- Collect path: on clk edge with bit_en=1, bit_in shifts in (MSB_FIRST=1: shift left, insert at bit 0; MSB_FIRST=0: shift right, insert at bit WIDTH-1); bit_cnt increments.
- Word completion: the bit_en edge where bit_cnt==WIDTH-1 completes the word; bit_cnt wraps to 0 on the same edge. The next word collects with no gap cycle.
- Output slot FSM, two states:
  EMPTY (word_valid=0): on completion, load word_out, go to FULL. word_valid rises 1 cycle after the completing bit_en edge.
  FULL (word_valid=1): word_ready=1 consumes the word. With no completion in the same cycle, go to EMPTY. With a completion in the same cycle, load the new word and stay FULL (no bubble, no overrun).
  FULL with word_ready=0 and a completion: new word dropped, word_out unchanged, overrun set to 1.
- overrun is sticky. It clears only on reset or clear.
- clear=1: shift register=0, bit_cnt=0, overrun=0. A bit_en in the same cycle is ignored. The output slot (word_out/word_valid) is unaffected, and a pending word still drains normally.
- word_out only changes on a load, never while word_valid=1 and word_ready=0.
- bit_en=0 for any number of cycles: no state change. The partial word is held indefinitely.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined: each frame is WIDTH data bits followed by one even-parity bit. bit_cnt counts to WIDTH, and completion occurs on the parity bit's bit_en edge. parity_err is loaded together with word_out and equals 1 when the XOR of the data bits and the parity bit is 1. parity_err is valid while word_valid=1 and clears on reset. Overrun and drop rules apply to the whole frame.
- Undefined: no parity bit is expected, and parity_err is tied to 0.

Test Plan:
- Reset/idle: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately; after release with bit_en=0 for 20 cycles -> word_valid stays 0, bit_cnt=0.
- Basic capture, WIDTH=8, MSB_FIRST=1: shift 1,0,1,1,0,0,1,0 on consecutive bit_en, word_ready=1 -> word_out=8'hB2, word_valid high for exactly 1 cycle, starting 1 cycle after the 8th strobe.
- LSB-first and sparse strobes: MSB_FIRST=0, same bit sequence with bit_en every 3rd cycle -> word_out=8'h4D; bit_cnt steps 0..7 and then wraps to 0.
- Back-pressure/overrun: word_ready=0, send 0xA5 then 0x3C -> word_out stays 0xA5, overrun=1 after the 2nd completion; raise word_ready -> 0xA5 consumed, word_valid=0, overrun still 1; pulse clear -> overrun=0.
- Simultaneous drain and load: hold 0x11 with word_ready=0, then assert word_ready on the same edge as the completion of 0x22 -> word_out=0x22, word_valid stays 1, overrun=0.
- Clear mid-word and parity (SIPO_PARITY_EN): 4 bits, then clear, then 0x0F with parity bit 0 -> word_out=0x0F, parity_err=0. Next, 0x07 with parity bit 0 -> parity_err=1.
